demux4_stream: RTL and testbench
================================

DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of input and of each output lane.
REQ-002 SHALL have parameter DEPTH, default 2, per-lane FIFO entries; legal values are powers of two and at least 2.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port sel_i  in  2  destination lane: 0=a, 1=b, 2=c, 3=d.
REQ-006 SHALL have port data_i  in  WIDTH  input word.
REQ-007 SHALL have port valid_i  in  1  input word and sel_i valid.
REQ-008 SHALL have port ready_o  out  1  block can accept the word for lane sel_i.
REQ-009 SHALL have ports a_o, b_o, c_o, d_o  out  WIDTH  head word of lanes 0..3.
REQ-010 SHALL have port valid_o  out  4  bit k set when lane k holds data.
REQ-011 SHALL have port ready_i  in  4  bit k: downstream k consumes the head word.

Function
REQ-012 SHALL accept a word when valid_i=1 and ready_o=1 on a rising edge; this is a push to lane sel_i.
REQ-013 SHALL drive ready_o = (rst_i=1) and (level[sel_i] < DEPTH). ready_o SHALL depend combinationally only on sel_i and registered state, never on ready_i or valid_i.
REQ-014 SHALL pop lane k when valid_o[k]=1 and ready_i[k]=1 on a rising edge.
REQ-015 SHALL set valid_o[k] = (level[k] != 0) from registered state.
REQ-016 SHALL drive each lane's data output from the lane's head entry. When valid_o[k]=0, the lane output holds its last value (0 after reset).
REQ-017 SHALL give a latency of exactly 1 cycle: a word pushed at edge N appears on its lane with valid_o set after edge N.
REQ-018 SHALL preserve per-lane order; words in different lanes are independent, with no cross-lane ordering.
REQ-019 SHALL ensure lanes never block each other: a full lane deasserts ready_o only while sel_i addresses it.
REQ-020 SHALL handle push and pop on the same lane in the same cycle, when the lane is not full, with level unchanged and order preserved.
REQ-021 SHALL NOT push through a full lane: with level=DEPTH, ready_o=0 even if ready_i[k]=1 in the same cycle.
REQ-022 SHALL leave state unchanged when a pop is requested with valid_o[k]=0 (empty lane); no underflow.
REQ-023 SHALL wrap read and write pointers modulo DEPTH. Level SHALL be held in clog2(DEPTH)+1 bits and never exceed DEPTH.
REQ-024 SHALL allow a push to lane i and pops on any lanes in the same cycle, all taking effect together.
REQ-025 SHALL ignore data_i and sel_i when valid_i=0.

Reset
REQ-026 SHALL, on rising edge with rst_i=0, clear all levels and pointers, set valid_o=4'b0000, and set a_o..d_o to 0.
REQ-027 SHALL hold ready_o=0 while rst_i=0.
REQ-028 SHALL, on reset mid-operation, discard all stored words. No word pushed before the reset edge SHALL appear afterwards.
REQ-029 SHALL accept a push on the first rising edge with rst_i=1.

Verification
REQ-030 SHALL cover: reset, then push 0x11 sel=0, 0x22 sel=1, 0x33 sel=2, 0x44 sel=3 with ready_i=4'b1111 -> each word on its lane one cycle after push, valid_o one-hot per cycle.
REQ-031 SHALL cover: ready_i=0, push 0xA1, 0xA2 to sel=2 -> valid_o[2]=1, ready_o=0 for sel=2; sel=0 push still accepted; release ready_i[2] -> c_o shows 0xA1 then 0xA2.
REQ-032 SHALL cover: lane 1 full (DEPTH=2) and ready_i[1]=1 with valid_i=1, sel=1 in the same cycle -> ready_o=0, one pop, level 1; push accepted next cycle.
REQ-033 SHALL cover: lane 3 holding one word, simultaneous push 0x5A and pop -> b..c unaffected, d_o=0x5A next cycle, valid_o[3] stays 1.
REQ-034 SHALL cover: all lanes partly filled, rst_i=0 for one cycle -> valid_o=0, a_o..d_o=0, ready_o=0 during reset; ready_o=1 after; no stale word emerges.
REQ-035 SHALL cover: random stream of 1000 words with random sel and random ready_i -> scoreboard shows per-lane order preserved, no loss or duplication, level never exceeds DEPTH.

Source files
------------

// File: rtl/demux4_stream_if.sv
// demux4_stream_if: input stream plus four output lanes of the 1-to-4 stream demultiplexer.
interface demux4_stream_if #(parameter int WIDTH = 8);
    logic [1:0]       sel_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic [WIDTH-1:0] c_o;
    logic [WIDTH-1:0] d_o;
    logic [3:0]       valid_o;
    logic [3:0]       ready_i;
    modport slave (input sel_i, data_i, valid_i, ready_i, output ready_o, a_o, b_o, c_o, d_o, valid_o);
    modport master(output sel_i, data_i, valid_i, ready_i, input ready_o, a_o, b_o, c_o, d_o, valid_o);
endinterface

// File: rtl/demux4_stream.sv
// demux4_stream: routes each input word to one of four independent per-lane FIFOs.
module demux4_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input logic clk_i,
    input logic rst_i,
    demux4_stream_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [LW-1:0]    lvl [4];
    logic [WIDTH-1:0] lane [4];
    logic [3:0]       vld;
    assign bus.ready_o = rst_i && (lvl[bus.sel_i] < LW'(DEPTH));
    assign bus.valid_o = vld;
    assign bus.a_o     = lane[0];
    assign bus.b_o     = lane[1];
    assign bus.c_o     = lane[2];
    assign bus.d_o     = lane[3];
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
        logic [LW-1:0]    lvl_q, lvl_d;
        logic [WIDTH-1:0] hold_q;
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic             push, pop;
        assign push    = bus.valid_i && bus.ready_o && (bus.sel_i == 2'(k));
        assign pop     = vld[k] && bus.ready_i[k];
        assign vld[k]  = lvl_q != '0;
        assign lvl[k]  = lvl_q;
        // an empty lane keeps presenting the last head it showed
        assign lane[k] = vld[k] ? mem_q[rd_q] : hold_q;
        always_comb begin
            rd_d  = pop ? rd_q + AW'(1) : rd_q;
            wr_d  = push ? wr_q + AW'(1) : wr_q;
            lvl_d = lvl_q + LW'(push) - LW'(pop);
        end
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                rd_q   <= '0;
                wr_q   <= '0;
                lvl_q  <= '0;
                hold_q <= '0;
            end else begin
                rd_q   <= rd_d;
                wr_q   <= wr_d;
                lvl_q  <= lvl_d;
                hold_q <= lane[k];
            end
        end
        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_q] <= bus.data_i;
        end
    end
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed scenarios plus a scoreboarded random stream for demux4_stream.
module tb_demux4_stream;
    localparam int DEPTH = 2;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] outs [4];
    demux4_stream_if #(.WIDTH(8)) bus ();
    demux4_stream #(.WIDTH(8), .DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
    always #5 clk_i = ~clk_i;
    assign outs[0] = bus.a_o;
    assign outs[1] = bus.b_o;
    assign outs[2] = bus.c_o;
    assign outs[3] = bus.d_o;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [1:0] s, input logic [7:0] d);
        bus.valid_i = 1'b1;
        bus.sel_i   = s;
        bus.data_i  = d;
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; bus.valid_i = 1'b0; bus.sel_i = 2'd0; bus.data_i = 8'h00; bus.ready_i = 4'h0;
        tick(); tick();
        n_cmp++; if (bus.valid_o !== 4'b0000) begin n_err++; $display("FAIL reset_valid got=%b exp=0000", bus.valid_o); end
        n_cmp++; if ({bus.a_o, bus.b_o, bus.c_o, bus.d_o} !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {bus.a_o, bus.b_o, bus.c_o, bus.d_o}); end
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
        rst_i = 1'b1; #1;
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b exp=1", bus.ready_o); end
    endtask

    task automatic test_basic();
        bus.ready_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 1'b1; bus.sel_i = 2'(i); bus.data_i = 8'(8'h11 * (i + 1));
            tick();
            n_cmp++; if (bus.valid_o !== 4'(1 << i)) begin n_err++; $display("FAIL basic_valid%0d got=%b exp=%b", i, bus.valid_o, 4'(1 << i)); end
            n_cmp++; if (outs[i] !== 8'(8'h11 * (i + 1))) begin n_err++; $display("FAIL basic_data%0d got=%h exp=%h", i, outs[i], 8'(8'h11 * (i + 1))); end
        end
        bus.valid_i = 1'b0;
        tick();
        n_cmp++; if (bus.valid_o !== 4'b0000) begin n_err++; $display("FAIL basic_drain got=%b exp=0000", bus.valid_o); end
        n_cmp++; if (bus.a_o !== 8'h11 || bus.d_o !== 8'h44) begin n_err++; $display("FAIL basic_hold got a=%h d=%h exp a=11 d=44", bus.a_o, bus.d_o); end
    endtask

    task automatic test_backpressure();
        bus.ready_i = 4'h0;
        push_word(2'd2, 8'hA1);
        push_word(2'd2, 8'hA2);
        bus.sel_i = 2'd2; #1;
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got=%b exp=0", bus.ready_o); end
        bus.sel_i = 2'd0; #1;
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL bp_other_ready got=%b exp=1", bus.ready_o); end
        push_word(2'd0, 8'hB0);
        n_cmp++; if (bus.valid_o !== 4'b0101 || bus.a_o !== 8'hB0) begin n_err++; $display("FAIL bp_lane0 got v=%b a=%h exp v=0101 a=b0", bus.valid_o, bus.a_o); end
        n_cmp++; if (bus.c_o !== 8'hA1) begin n_err++; $display("FAIL bp_first got=%h exp=a1", bus.c_o); end
        bus.ready_i = 4'b0100;
        tick();
        n_cmp++; if (bus.c_o !== 8'hA2 || bus.valid_o !== 4'b0101) begin n_err++; $display("FAIL bp_second got c=%h v=%b exp c=a2 v=0101", bus.c_o, bus.valid_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 4'b0001 || bus.c_o !== 8'hA2) begin n_err++; $display("FAIL bp_empty got c=%h v=%b exp c=a2 v=0001", bus.c_o, bus.valid_o); end
        bus.ready_i = 4'hF;
        tick();
        n_cmp++; if (bus.valid_o !== 4'b0000) begin n_err++; $display("FAIL bp_drain got=%b exp=0000", bus.valid_o); end
    endtask

    task automatic test_full_pop();
        bus.ready_i = 4'h0;
        push_word(2'd1, 8'h61);
        push_word(2'd1, 8'h62);
        bus.valid_i = 1'b1; bus.sel_i = 2'd0; bus.data_i = 8'h63; #1;
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL full_other_lane got=%b exp=1", bus.ready_o); end
        bus.sel_i = 2'd1; bus.ready_i = 4'b0010; #1;
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", bus.ready_o); end
        tick();
        n_cmp++; if (bus.b_o !== 8'h62 || bus.valid_o !== 4'b0010) begin n_err++; $display("FAIL full_onepop got b=%h v=%b exp b=62 v=0010", bus.b_o, bus.valid_o); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL full_level1_ready got=%b exp=1", bus.ready_o); end
        bus.ready_i = 4'h0;
        tick();
        bus.valid_i = 1'b0;
        n_cmp++; if (bus.ready_o !== 1'b0 || bus.b_o !== 8'h62) begin n_err++; $display("FAIL full_repush got r=%b b=%h exp r=0 b=62", bus.ready_o, bus.b_o); end
        bus.ready_i = 4'b0010;
        tick();
        n_cmp++; if (bus.b_o !== 8'h63) begin n_err++; $display("FAIL full_order got=%h exp=63", bus.b_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 4'b0000) begin n_err++; $display("FAIL full_drain got=%b exp=0000", bus.valid_o); end
    endtask

    task automatic test_same_cycle();
        bus.ready_i = 4'h0;
        push_word(2'd1, 8'h10);
        push_word(2'd2, 8'h20);
        push_word(2'd3, 8'h3C);
        bus.valid_i = 1'b1; bus.sel_i = 2'd3; bus.data_i = 8'h5A; bus.ready_i = 4'b1000;
        tick();
        bus.valid_i = 1'b0; bus.ready_i = 4'h0;
        n_cmp++; if (bus.d_o !== 8'h5A || bus.valid_o !== 4'b1110) begin n_err++; $display("FAIL same_d got d=%h v=%b exp d=5a v=1110", bus.d_o, bus.valid_o); end
        n_cmp++; if (bus.b_o !== 8'h10 || bus.c_o !== 8'h20) begin n_err++; $display("FAIL same_others got b=%h c=%h exp b=10 c=20", bus.b_o, bus.c_o); end
        bus.ready_i = 4'hF;
        tick();
        n_cmp++; if (bus.valid_o !== 4'b0000) begin n_err++; $display("FAIL same_drain got=%b exp=0000", bus.valid_o); end
    endtask

    task automatic test_empty_pop();
        bus.ready_i = 4'hF; bus.valid_i = 1'b0; bus.sel_i = 2'd2; bus.data_i = 8'hFF;
        tick(); tick();
        n_cmp++; if (bus.valid_o !== 4'b0000 || bus.c_o !== 8'h20) begin n_err++; $display("FAIL empty_pop got v=%b c=%h exp v=0000 c=20", bus.valid_o, bus.c_o); end
        for (int s = 0; s < 4; s++) begin
            bus.sel_i = 2'(s); #1;
            n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL empty_ready%0d got=%b exp=1", s, bus.ready_o); end
        end
    endtask

    task automatic test_reset_mid();
        bus.ready_i = 4'h0;
        for (int s = 0; s < 4; s++) push_word(2'(s), 8'(8'h81 + s));
        n_cmp++; if (bus.valid_o !== 4'hF) begin n_err++; $display("FAIL mid_fill got=%b exp=1111", bus.valid_o); end
        rst_i = 1'b0; #1;
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL mid_ready_in_reset got=%b exp=0", bus.ready_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 4'b0000 || {bus.a_o, bus.b_o, bus.c_o, bus.d_o} !== 32'h0) begin n_err++; $display("FAIL mid_cleared got v=%b data=%h exp 0", bus.valid_o, {bus.a_o, bus.b_o, bus.c_o, bus.d_o}); end
        rst_i = 1'b1; bus.valid_i = 1'b1; bus.sel_i = 2'd0; bus.data_i = 8'h77; #1;
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL mid_ready_after got=%b exp=1", bus.ready_o); end
        tick();
        bus.valid_i = 1'b0;
        n_cmp++; if (bus.valid_o !== 4'b0001 || bus.a_o !== 8'h77) begin n_err++; $display("FAIL mid_first_push got v=%b a=%h exp v=0001 a=77", bus.valid_o, bus.a_o); end
        bus.ready_i = 4'hF;
        tick(); tick();
        n_cmp++; if (bus.valid_o !== 4'b0000) begin n_err++; $display("FAIL mid_stale got=%b exp=0000", bus.valid_o); end
    endtask

    task automatic test_random();
        logic [7:0] q [4][$];
        int pushed = 0;
        int cyc = 0;
        int drain = 0;
        logic exp_rdy;
        while ((pushed < 1000 || drain < DEPTH + 2) && cyc < 20000) begin
            if (pushed < 1000) begin
                bus.valid_i = ($urandom_range(0, 3) != 0);
                bus.sel_i   = 2'($urandom_range(0, 3));
                bus.data_i  = 8'($urandom);
                bus.ready_i = 4'($urandom);
            end else begin
                bus.valid_i = 1'b0;
                bus.ready_i = 4'hF;
                drain++;
            end
            #1;
            exp_rdy = q[bus.sel_i].size() < DEPTH;
            n_cmp++; if (bus.ready_o !== exp_rdy) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.ready_o, exp_rdy); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (bus.valid_o[k] !== (q[k].size() != 0)) begin n_err++; $display("FAIL rnd_valid%0d cyc=%0d got=%b exp=%b", k, cyc, bus.valid_o[k], q[k].size() != 0); end
                if (q[k].size() != 0) begin
                    n_cmp++; if (outs[k] !== q[k][0]) begin n_err++; $display("FAIL rnd_data%0d cyc=%0d got=%h exp=%h", k, cyc, outs[k], q[k][0]); end
                end
            end
            for (int k = 0; k < 4; k++) if (q[k].size() != 0 && bus.ready_i[k]) void'(q[k].pop_front());
            if (bus.valid_i && exp_rdy) begin
                q[bus.sel_i].push_back(bus.data_i);
                pushed++;
            end
            tick();
            cyc++;
        end
        n_cmp++; if (pushed < 1000) begin n_err++; $display("FAIL rnd_budget got=%0d exp=1000", pushed); end
        n_cmp++; if (bus.valid_o !== 4'b0000) begin n_err++; $display("FAIL rnd_final got=%b exp=0000", bus.valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pop();
        test_same_cycle();
        test_empty_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
